// File: rtl/exe_wb_slot_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_wb_slot_scheduler_if : issue/writeback bundle for one lane     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface exe_wb_slot_scheduler_if #(
  parameter int SIZE_AL = 7
);
  logic               recoverFlag_i;
  logic               issueValid_i;
  logic               issueIsCplx_i;
  logic               issueIsDiv_i;
  logic [SIZE_AL-1:0] issueAlId_i;
  logic               grantSimple_o;
  logic               grantCplx_o;
  logic               grantDiv_o;
  logic               divBusy_o;
  logic               wbValid_o;
  logic               wbSelCplx_o;
  logic [SIZE_AL-1:0] wbAlId_o;
  logic               violation_o;
  logic [4:0]         inflight_o;

  modport master (
    output recoverFlag_i, issueValid_i, issueIsCplx_i, issueIsDiv_i, issueAlId_i,
    input  grantSimple_o, grantCplx_o, grantDiv_o, divBusy_o, wbValid_o,
    input  wbSelCplx_o, wbAlId_o, violation_o, inflight_o
  );

  modport slave (
    input  recoverFlag_i, issueValid_i, issueIsCplx_i, issueIsDiv_i, issueAlId_i,
    output grantSimple_o, grantCplx_o, grantDiv_o, divBusy_o, wbValid_o,
    output wbSelCplx_o, wbAlId_o, violation_o, inflight_o
  );
endinterface
`default_nettype wire

// File: rtl/exe_wb_slot_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_wb_slot_scheduler : writeback-slot reservation and issue grant |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module exe_wb_slot_scheduler #(
  parameter int CPLX_DEPTH  = 4,
  parameter int DIV_LATENCY = 8,
  parameter int SIZE_AL     = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  exe_wb_slot_scheduler_if.slave  wb_if
);

  localparam int c_L     = DIV_LATENCY + 1;
  localparam int c_IDX_W = $clog2(c_L);
  localparam logic [c_IDX_W-1:0] c_IDX_CPLX = c_IDX_W'(CPLX_DEPTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_DIV  = c_IDX_W'(DIV_LATENCY - 1);

  logic [c_L-1:0]     r_slot, r_kind, r_is_div;
  logic [c_L-1:0]     w_slot_nxt, w_kind_nxt, w_is_div_nxt;
  logic [SIZE_AL-1:0] r_id     [c_L];
  logic [SIZE_AL-1:0] w_id_nxt [c_L];
  logic               r_div_busy, w_div_busy_nxt;
  logic               r_violation, w_violation_nxt;
  logic [4:0]         r_inflight, w_inflight_nxt;
  logic               w_recover, w_div_wb, w_is_div_op;
  logic               w_grant_simple, w_grant_cplx, w_grant_div, w_grant_sel, w_accept;
  logic [c_IDX_W-1:0] w_rsv_idx;
  int                 w_count;

  always_comb begin
    w_recover   = wb_if.recoverFlag_i;
    w_is_div_op = wb_if.issueIsCplx_i & wb_if.issueIsDiv_i;
    // The divide leaving slot 0 this cycle frees the divider for a back-to-back divide.
    w_div_wb       = r_slot[0] & r_is_div[0];
    w_grant_simple = ~r_slot[1] & ~w_recover;
    w_grant_cplx   = ~r_slot[CPLX_DEPTH] & ~w_recover;
    w_grant_div    = (~r_div_busy | w_div_wb) & ~r_slot[DIV_LATENCY] & ~w_recover;

    w_grant_sel = wb_if.issueIsCplx_i ? (wb_if.issueIsDiv_i ? w_grant_div : w_grant_cplx)
                                      : w_grant_simple;
    w_accept        = wb_if.issueValid_i & w_grant_sel;
    w_violation_nxt = wb_if.issueValid_i & ~w_recover & ~w_grant_sel;
    w_rsv_idx       = wb_if.issueIsCplx_i ? (wb_if.issueIsDiv_i ? c_IDX_DIV : c_IDX_CPLX)
                                          : '0;

    w_slot_nxt   = r_slot >> 1;
    w_kind_nxt   = r_kind >> 1;
    w_is_div_nxt = r_is_div >> 1;
    for (int i = 0; i < c_L - 1; i++) begin
      w_id_nxt[i] = r_id[i+1];
    end
    w_id_nxt[c_L-1] = '0;
    w_div_busy_nxt  = r_div_busy & ~w_div_wb;

    if (w_accept) begin
      w_slot_nxt[w_rsv_idx]   = 1'b1;
      w_kind_nxt[w_rsv_idx]   = wb_if.issueIsCplx_i;
      w_is_div_nxt[w_rsv_idx] = w_is_div_op;
      w_id_nxt[w_rsv_idx]     = wb_if.issueAlId_i;
      if (w_is_div_op) begin
        w_div_busy_nxt = 1'b1;
      end
    end

    if (w_recover) begin
      w_slot_nxt     = '0;
      w_kind_nxt     = '0;
      w_is_div_nxt   = '0;
      w_div_busy_nxt = 1'b0;
      for (int i = 0; i < c_L; i++) begin
        w_id_nxt[i] = '0;
      end
    end

    w_count = 0;
    for (int i = 0; i < c_L; i++) begin
      if (w_slot_nxt[i]) begin
        w_count = w_count + 1;
      end
    end
    w_inflight_nxt = (w_count > 31) ? 5'd31 : w_count[4:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot      <= '0;
      r_kind      <= '0;
      r_is_div    <= '0;
      r_div_busy  <= 1'b0;
      r_violation <= 1'b0;
      r_inflight  <= '0;
      for (int i = 0; i < c_L; i++) begin
        r_id[i] <= '0;
      end
    end else begin
      r_slot      <= w_slot_nxt;
      r_kind      <= w_kind_nxt;
      r_is_div    <= w_is_div_nxt;
      r_div_busy  <= w_div_busy_nxt;
      r_violation <= w_violation_nxt;
      r_inflight  <= w_inflight_nxt;
      for (int i = 0; i < c_L; i++) begin
        r_id[i] <= w_id_nxt[i];
      end
    end
  end

  assign wb_if.grantSimple_o = w_grant_simple;
  assign wb_if.grantCplx_o   = w_grant_cplx;
  assign wb_if.grantDiv_o    = w_grant_div;
  assign wb_if.divBusy_o     = r_div_busy;
  assign wb_if.wbValid_o     = r_slot[0];
  assign wb_if.wbSelCplx_o   = r_slot[0] & r_kind[0];
  assign wb_if.wbAlId_o      = r_slot[0] ? r_id[0] : '0;
  assign wb_if.violation_o   = r_violation;
  assign wb_if.inflight_o    = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_exe_wb_slot_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exe_wb_slot_scheduler : random + directed bench, schedule model |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_exe_wb_slot_scheduler;

  localparam int CD = 4;
  localparam int DL = 8;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exe_wb_slot_scheduler_if #(.SIZE_AL(AW)) bus ();

  exe_wb_slot_scheduler #(
    .CPLX_DEPTH  (CD),
    .DIV_LATENCY (DL),
    .SIZE_AL     (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb_if (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference: writebacks keyed by the absolute cycle in which they appear.
  bit            m_kind [int];
  logic [AW-1:0] m_id   [int];
  int            m_div_due = -1;
  bit            m_viol    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_grant(input bit cplx, input bit div, input bit rec);
    if (rec) return 1'b0;
    if (!cplx) return !m_kind.exists(cyc + 1);
    if (!div) return !m_kind.exists(cyc + CD);
    return (m_div_due <= cyc) && !m_kind.exists(cyc + DL);
  endfunction

  function automatic int m_inflight();
    int n = 0;
    foreach (m_kind[k]) if (k >= cyc) n++;
    return (n > 31) ? 31 : n;
  endfunction

  task automatic check_outputs(input bit rec);
    bit            v = m_kind.exists(cyc);
    logic [AW-1:0] id = v ? m_id[cyc] : '0;
    check_val("wb_valid",     32'(bus.wbValid_o),    32'(v));
    check_val("wb_sel_cplx",  32'(bus.wbSelCplx_o),  32'(v ? m_kind[cyc] : 1'b0));
    check_val("wb_al_id",     32'(bus.wbAlId_o),     32'(id));
    check_val("grant_simple", 32'(bus.grantSimple_o), 32'(m_grant(1'b0, 1'b0, rec)));
    check_val("grant_cplx",   32'(bus.grantCplx_o),  32'(m_grant(1'b1, 1'b0, rec)));
    check_val("grant_div",    32'(bus.grantDiv_o),   32'(m_grant(1'b1, 1'b1, rec)));
    check_val("div_busy",     32'(bus.divBusy_o),    32'(m_div_due >= cyc));
    check_val("violation",    32'(bus.violation_o),  32'(m_viol));
    check_val("inflight",     32'(bus.inflight_o),   32'(m_inflight()));
  endtask

  task automatic step(input bit v, input bit cplx, input bit div,
                      input logic [AW-1:0] id, input bit rec);
    bit g;
    @(negedge clk);
    bus.issueValid_i  = v;
    bus.issueIsCplx_i = cplx;
    bus.issueIsDiv_i  = cplx & div;
    bus.issueAlId_i   = id;
    bus.recoverFlag_i = rec;
    #1 check_outputs(rec);
    g = m_grant(cplx, cplx & div, rec);
    @(posedge clk);
    if (m_kind.exists(cyc)) begin
      m_kind.delete(cyc);
      m_id.delete(cyc);
    end
    if (rec) begin
      m_kind.delete();
      m_id.delete();
      m_div_due = -1;
      m_viol    = 1'b0;
    end else if (v) begin
      m_viol = !g;
      if (g) begin
        int due = cyc + (!cplx ? 1 : (div ? DL : CD));
        m_kind[due] = cplx;
        m_id[due]   = id;
        if (cplx && div) m_div_due = due;
      end
    end else begin
      m_viol = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset             = 1'b0;
    bus.recoverFlag_i = 1'b0;
    bus.issueValid_i  = 1'b0;
    bus.issueIsCplx_i = 1'b0;
    bus.issueIsDiv_i  = 1'b0;
    bus.issueAlId_i   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_outputs(1'b0);
    reset = 1'b1;

    // Complex op, id 5
    step(1'b1, 1'b1, 1'b0, 7'd5, 1'b0);
    idle(6);
    // Divide id 9, colliding divide three cycles later
    step(1'b1, 1'b1, 1'b1, 7'd9, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 7'd10, 1'b0);
    idle(10);
    // Back-to-back simple ops
    step(1'b1, 1'b0, 1'b0, 7'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7'd3, 1'b0);
    idle(3);
    // Complex, divide, then recovery with a simple issue
    step(1'b1, 1'b1, 1'b0, 7'd4, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7'd6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7'd7, 1'b1);
    idle(10);
    // Complex blocked by a divide holding its slot
    step(1'b1, 1'b1, 1'b1, 7'd11, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 7'd12, 1'b0);
    idle(8);
    // Divide writes back in the same cycle a new divide issues
    step(1'b1, 1'b1, 1'b1, 7'd20, 1'b0);
    idle(7);
    step(1'b1, 1'b1, 1'b1, 7'd21, 1'b0);
    idle(10);

    for (int n = 0; n < 3000; n++) begin
      bit            v    = ($urandom_range(0, 9) < 7);
      bit            cplx = ($urandom_range(0, 9) < 4);
      bit            div  = cplx && ($urandom_range(0, 3) == 0);
      bit            rec  = ($urandom_range(0, 99) < 3);
      logic [AW-1:0] id   = AW'($urandom);
      if (v && !m_grant(cplx, div, 1'b0) && ($urandom_range(0, 4) != 0)) v = 1'b0;
      step(v, cplx, div, id, rec);
    end

    // Asynchronous reset with three ops in flight
    idle(12);
    step(1'b1, 1'b1, 1'b0, 7'd1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7'd3, 1'b0);
    @(negedge clk);
    bus.issueValid_i  = 1'b0;
    bus.recoverFlag_i = 1'b0;
    check_val("pre_reset_inflight", 32'(bus.inflight_o), 32'(3));
    reset = 1'b0;
    #1;
    check_val("rst_wb_valid",     32'(bus.wbValid_o),     32'(0));
    check_val("rst_wb_sel",       32'(bus.wbSelCplx_o),   32'(0));
    check_val("rst_wb_id",        32'(bus.wbAlId_o),      32'(0));
    check_val("rst_div_busy",     32'(bus.divBusy_o),     32'(0));
    check_val("rst_violation",    32'(bus.violation_o),   32'(0));
    check_val("rst_inflight",     32'(bus.inflight_o),    32'(0));
    check_val("rst_grant_simple", 32'(bus.grantSimple_o), 32'(1));
    check_val("rst_grant_cplx",   32'(bus.grantCplx_o),   32'(1));
    check_val("rst_grant_div",    32'(bus.grantDiv_o),    32'(1));
    m_kind.delete();
    m_id.delete();
    m_div_due = -1;
    m_viol    = 1'b0;
    #2 reset = 1'b1;
    idle(3);
    step(1'b1, 1'b1, 1'b0, 7'd33, 1'b0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
